// File: rtl/branch_pipe_ctrl.sv
// Branch/hazard sequencer for the 5-stage MIPS pipeline: resolves BEQ in EX, drives PC redirect,
// IF/ID and ID/EX stall/flush controls. Define BRANCH_BNE_EN to also resolve BNE as a branch.
module branch_pipe_ctrl #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CNT_W       = 16,
  parameter int ADDR_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ex_valid,
  input  logic [5:0]        i_opcode,
  input  logic              i_zero,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_load_use,
  input  logic              i_imem_ready,
  output logic              o_pc_src,
  output logic [ADDR_W-1:0] o_pc_target,
  output logic              o_pc_write,
  output logic              o_ifid_write,
  output logic              o_ifid_flush,
  output logic              o_idex_flush,
  output logic [CNT_W-1:0]  o_taken_cnt,
  output logic              o_busy
);

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam int         FW     = $clog2(FLUSH_DEPTH + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(FLUSH_DEPTH - 1);
  localparam bit         HAS_FLUSH = (FLUSH_DEPTH > 1);

  typedef enum logic [1:0] {RUN, REDIRECT, FLUSH} state_e;

  state_e              state_q, state_d;
  logic [FW-1:0]       fcnt_q, fcnt_d;
  logic [ADDR_W-1:0]   tgt_q, tgt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                taken;
  logic                pc_src, pc_write, ifid_write, ifid_flush, idex_flush;
  logic [ADDR_W-1:0]   pc_target;

`ifdef BRANCH_BNE_EN
  localparam logic [5:0] OP_BNE = 6'b000101;
  assign taken = i_ex_valid & (((i_opcode == OP_BEQ) & i_zero) | ((i_opcode == OP_BNE) & ~i_zero));
`else
  assign taken = i_ex_valid & (i_opcode == OP_BEQ) & i_zero;
`endif

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    tgt_d      = tgt_q;
    cnt_d      = cnt_q;
    pc_src     = 1'b0;
    pc_target  = i_branch_target;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state_q)
      RUN: begin
        if (taken) begin
          pc_src     = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          tgt_d      = i_branch_target;
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
          pc_write   = i_imem_ready;
          ifid_write = i_imem_ready;
          if (!i_imem_ready) begin
            state_d = REDIRECT;
          end else if (HAS_FLUSH) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_INIT;
          end
        end else if (!i_imem_ready) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = i_load_use;
        end else if (i_load_use) begin
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
        end
      end
      REDIRECT: begin
        // Fetch stalled on the redirect: keep presenting the latched target until memory accepts it.
        pc_src     = 1'b1;
        pc_target  = tgt_q;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        pc_write   = i_imem_ready;
        ifid_write = i_imem_ready;
        if (i_imem_ready) begin
          if (HAS_FLUSH) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_INIT;
          end else begin
            state_d = RUN;
          end
        end
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        pc_write   = i_imem_ready;
        ifid_write = i_imem_ready;
        if (i_imem_ready) begin
          fcnt_d = fcnt_q - FW'(1);
          if (fcnt_q == FW'(1)) state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset overrides the control outputs so nothing is written while the pipe is held.
  assign o_pc_src     = i_rst_n & pc_src;
  assign o_pc_target  = i_rst_n ? pc_target : '0;
  assign o_pc_write   = i_rst_n & pc_write;
  assign o_ifid_write = i_rst_n & ifid_write;
  assign o_ifid_flush = ~i_rst_n | ifid_flush;
  assign o_idex_flush = ~i_rst_n | idex_flush;
  assign o_taken_cnt  = cnt_q;
  assign o_busy       = i_rst_n & (state_q != RUN);

endmodule

// File: doc/branch_pipe_ctrl.md
Name: branch_pipe_ctrl

Overview:
Central branch/hazard sequencer for the 5-stage MIPS pipeline. Resolves BEQ in EX from opcode and ALU zero flag, drives PC-source select and PC target, and generates IF/ID and ID/EX write-enable and flush controls. Arbitrates three PC-update sources: taken-branch redirect, instruction-memory wait, and load-use stall. Keeps a saturating taken-branch counter.

Parameters:
FLUSH_DEPTH, 2, total cycles flushes are held after a taken branch (>=1)
CNT_W, 16, width of taken-branch counter
ADDR_W, 32, PC/target width

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  async active-low reset
i_ex_valid  in  1  EX stage holds a valid (non-bubble) instruction
i_opcode  in  6  EX-stage opcode
i_zero  in  1  ALU zero flag for the EX instruction
i_branch_target  in  ADDR_W  EX-computed branch target
i_load_use  in  1  load-use hazard detected in ID
i_imem_ready  in  1  instruction memory returns fetch this cycle
o_pc_src  out  1  1 = PC loads o_pc_target, 0 = PC+4
o_pc_target  out  ADDR_W  redirect address
o_pc_write  out  1  PC register enable
o_ifid_write  out  1  IF/ID register enable
o_ifid_flush  out  1  zero IF/ID this cycle
o_idex_flush  out  1  insert bubble into ID/EX this cycle
o_taken_cnt  out  CNT_W  saturating count of taken branches
o_busy  out  1  state != RUN

Behaviour:
- taken = i_ex_valid & (i_opcode==6'b000100) & i_zero; evaluated only in RUN.
- States: RUN, REDIRECT, FLUSH. Registers: state, flush counter fcnt, target latch tgt_q, o_taken_cnt.
- Reset (i_rst_n low, async): state=RUN, fcnt=0, tgt_q=0, o_taken_cnt=0. While reset is held, outputs are forced: o_pc_src=0, o_pc_target=0, o_pc_write=0, o_ifid_write=0, o_ifid_flush=1, o_idex_flush=1, o_busy=0. Reset mid-redirect discards the pending target.
- RUN priority (same-cycle, combinational outputs):
  1. taken: o_pc_src=1, o_pc_target=i_branch_target, o_ifid_flush=1, o_idex_flush=1, tgt_q<=i_branch_target, o_taken_cnt += 1 (saturating at all-ones). If i_imem_ready: o_pc_write=1, o_ifid_write=1; next = FLUSH when FLUSH_DEPTH>1 (fcnt<=FLUSH_DEPTH-1), else RUN. If !i_imem_ready: o_pc_write=0, o_ifid_write=0; next = REDIRECT.
  2. !i_imem_ready: o_pc_write=0, o_ifid_write=0, o_idex_flush=i_load_use; otherwise defaults.
  3. i_load_use: o_pc_write=0, o_ifid_write=0, o_idex_flush=1 (one bubble per asserted cycle).
  4. Default: o_pc_src=0, o_pc_write=1, o_ifid_write=1, flushes=0.
- REDIRECT: o_pc_src=1, o_pc_target=tgt_q, o_ifid_flush=1, o_idex_flush=1, o_pc_write=o_ifid_write=i_imem_ready. On i_imem_ready, next = FLUSH (fcnt<=FLUSH_DEPTH-1) or RUN if FLUSH_DEPTH==1. Branch and load-use inputs are ignored (wrong path).
- FLUSH: o_pc_src=0, o_ifid_flush=1, o_idex_flush=1, o_pc_write=o_ifid_write=i_imem_ready. fcnt decrements only when i_imem_ready. On fcnt==1 with ready, next = RUN. Branch and load-use inputs are ignored.
- Non-BEQ opcodes, or i_ex_valid=0, never redirect, even with i_zero=1.
- Counter saturates and never wraps.

Optional Feature:
BRANCH_BNE_EN. When defined, taken also includes i_ex_valid & (i_opcode==6'b000101) & ~i_zero, and BNE counts toward o_taken_cnt. When undefined, opcode 000101 is treated as a non-branch.

Test Plan:
- Reset, then i_ex_valid=1, opcode=000100, zero=1, target=0x40, imem_ready=1 -> same cycle pc_src=1, pc_target=0x40, both flushes=1; next cycle FLUSH with flushes=1, pc_src=0; cycle after, RUN; taken_cnt=1.
- Same BEQ with zero=0, then opcode=000101 with zero=0 (macro off) -> pc_src stays 0, no flushes, taken_cnt=0. Repeat with BRANCH_BNE_EN -> BNE redirects, taken_cnt=1.
- Taken BEQ, target=0x100, imem_ready=0 for 3 cycles -> REDIRECT holds pc_target=0x100, pc_write=0, flushes=1. Ready rises -> pc_write=1, then FLUSH, then RUN.
- i_load_use=1 for 1 cycle in RUN -> pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0. Load_use together with taken -> branch wins (both flushes=1, pc_write=1).
- CNT_W=2: 5 taken branches -> o_taken_cnt 1,2,3,3,3.
- Assert i_rst_n=0 mid-REDIRECT -> immediately state RUN, pc_src=0, taken_cnt=0. After release, no stale redirect to tgt_q.
